// File: rtl/ahb_sub_mem_pkg.sv
// ahb_sub_mem_pkg: shared AHB encodings and helpers for the ahb_sub_mem subordinate.
//   TRANS_*           HTRANS encodings
//   RESP_*            HRESP encodings
//   sub_mem_state_e   data-phase FSM states
//   size_lane_mask()  HSIZE + byte offset -> 8-lane byte-enable mask
package ahb_sub_mem_pkg;

    localparam logic [1:0] TRANS_IDLE   = 2'b00;
    localparam logic [1:0] TRANS_BUSY   = 2'b01;
    localparam logic [1:0] TRANS_NONSEQ = 2'b10;
    localparam logic [1:0] TRANS_SEQ    = 2'b11;

    localparam logic RESP_OKAY  = 1'b0;
    localparam logic RESP_ERROR = 1'b1;

    typedef enum logic [2:0] {
        StIdle,
        StWait,
        StData,
        StErr1,
        StErr2
    } sub_mem_state_e;

    // Byte-enable mask for a transfer of 2^size bytes starting at byte lane 'offset'.
    // Sizes above 64 bits give an empty mask; such transfers are rejected as errors anyway.
    function automatic logic [7:0] size_lane_mask(input logic [2:0] size,
                                                  input logic [2:0] offset);
        logic [7:0] base;
        case (size)
            3'd0:    base = 8'h01;
            3'd1:    base = 8'h03;
            3'd2:    base = 8'h0f;
            3'd3:    base = 8'hff;
            default: base = 8'h00;
        endcase
        return base << offset;
    endfunction

endpackage

// File: rtl/ahb_sub_mem_lanes.sv
// ahb_sub_mem_lanes: combinational byte-lane decode for one AHB address phase.
//   addr_low    in   low three address bits
//   size        in   HSIZE (log2 bytes)
//   lane_mask   out  byte enables within one DATA_WIDTH word
//   misaligned  out  address not aligned to the transfer size
module ahb_sub_mem_lanes
    import ahb_sub_mem_pkg::*;
#(
    parameter int unsigned DATA_WIDTH = 32
) (
    input  logic [2:0]              addr_low,
    input  logic [2:0]              size,
    output logic [DATA_WIDTH/8-1:0] lane_mask,
    output logic                    misaligned
);

    localparam int unsigned BYTES       = DATA_WIDTH / 8;
    localparam logic [2:0]  OFFSET_MASK = 3'(BYTES - 1);

    logic [2:0] offset;
    logic [2:0] align_mask;

    always_comb begin
        offset    = addr_low & OFFSET_MASK;
        lane_mask = BYTES'(size_lane_mask(size, offset));
        case (size)
            3'd0:    align_mask = 3'b000;
            3'd1:    align_mask = 3'b001;
            3'd2:    align_mask = 3'b011;
            default: align_mask = 3'b111;
        endcase
        misaligned = (addr_low & align_mask) != 3'b000;
    end

endmodule

// File: rtl/ahb_sub_mem.sv
// ahb_sub_mem: AHB subordinate backed by a word-addressed memory, with programmable wait
// states, two-cycle ERROR responses and read-after-write forwarding.
//   clk, reset      clock, asynchronous active-high reset
//   sel, trans      decoder select, HTRANS
//   write, addr     HWRITE, byte address
//   size, wData     HSIZE, write data (data phase)
//   readyIn         bus HREADY
//   errInject       force ERROR for the transfer sampled with it high
//   rData           read data
//   readyOut, resp  HREADYOUT, HRESP
// Build option: define AHB_SUB_MEM_BURST_CHECK_EN to reject SEQ transfers whose address does
// not follow the previous accepted transfer (or that follow IDLE/ERROR).
module ahb_sub_mem
    import ahb_sub_mem_pkg::*;
#(
    parameter int unsigned ADDR_WIDTH  = 32,
    parameter int unsigned DATA_WIDTH  = 32,
    parameter int unsigned DEPTH       = 256,
    parameter int unsigned WAIT_STATES = 0
) (
    input  logic                  clk,
    input  logic                  reset,
    input  logic                  sel,
    input  logic [1:0]            trans,
    input  logic                  write,
    input  logic [ADDR_WIDTH-1:0] addr,
    input  logic [2:0]            size,
    input  logic [DATA_WIDTH-1:0] wData,
    input  logic                  readyIn,
    input  logic                  errInject,
    output logic [DATA_WIDTH-1:0] rData,
    output logic                  readyOut,
    output logic                  resp
);

    localparam int unsigned BYTES    = DATA_WIDTH / 8;
    localparam int unsigned OFF_W    = $clog2(BYTES);
    localparam int unsigned IDX_W    = $clog2(DEPTH);
    localparam logic [3:0]  WAIT_CNT = 4'(WAIT_STATES);

    sub_mem_state_e        state_q, state_d;
    logic [3:0]            wait_cnt_q, wait_cnt_d;
    logic [IDX_W-1:0]      idx_q;
    logic                  write_q;
    logic [BYTES-1:0]      mask_q;
    logic [DATA_WIDTH-1:0] rdata_q, rdata_d;
    logic [DATA_WIDTH-1:0] mem [DEPTH];

    logic                  ready_state;
    logic                  accept;
    logic                  out_of_range;
    logic                  size_bad;
    logic                  misaligned;
    logic                  burst_err;
    logic                  xfer_err;
    logic [BYTES-1:0]      lane_mask;
    logic [IDX_W-1:0]      addr_idx;
    logic [IDX_W-1:0]      rd_idx;
    logic                  rd_is_read;

    ahb_sub_mem_lanes #(
        .DATA_WIDTH(DATA_WIDTH)
    ) u_lanes (
        .addr_low  (addr[2:0]),
        .size      (size),
        .lane_mask (lane_mask),
        .misaligned(misaligned)
    );

    // A new address phase is only taken while no data phase is stalling the bus.
    always_comb begin
        ready_state  = (state_q == StIdle) || (state_q == StData) || (state_q == StErr2);
        accept       = ready_state && sel && readyIn &&
                       ((trans == TRANS_NONSEQ) || (trans == TRANS_SEQ));
        addr_idx     = addr[IDX_W+OFF_W-1:OFF_W];
        out_of_range = (addr >> (IDX_W + OFF_W)) != '0;
        size_bad     = size > 3'(OFF_W);
        xfer_err     = out_of_range || size_bad || misaligned || errInject || burst_err;
    end

`ifdef AHB_SUB_MEM_BURST_CHECK_EN
    logic [ADDR_WIDTH-1:0] burst_addr_q;
    logic                  burst_valid_q;

    always_comb begin
        burst_err = (trans == TRANS_SEQ) &&
                    (!burst_valid_q || (addr != burst_addr_q + (ADDR_WIDTH'(1) << size)));
    end

    // burst_valid_q drops on IDLE / deselect and after any errored transfer; BUSY keeps it.
    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            burst_addr_q  <= '0;
            burst_valid_q <= 1'b0;
        end else if (accept) begin
            burst_addr_q  <= addr;
            burst_valid_q <= !xfer_err;
        end else if (ready_state && readyIn && (!sel || (trans == TRANS_IDLE))) begin
            burst_valid_q <= 1'b0;
        end
    end
`else
    always_comb begin
        burst_err = 1'b0;
    end
`endif

    // Next-state logic.
    always_comb begin
        state_d    = state_q;
        wait_cnt_d = wait_cnt_q;
        unique case (state_q)
            StIdle, StData, StErr2: begin
                if (accept) begin
                    if (xfer_err) begin
                        state_d = StErr1;
                    end else if (WAIT_STATES == 0) begin
                        state_d = StData;
                    end else begin
                        state_d    = StWait;
                        wait_cnt_d = WAIT_CNT;
                    end
                end else begin
                    state_d = StIdle;
                end
            end
            StWait: begin
                if (wait_cnt_q == 4'd1) begin
                    state_d    = StData;
                    wait_cnt_d = 4'd0;
                end else begin
                    wait_cnt_d = wait_cnt_q - 4'd1;
                end
            end
            StErr1:  state_d = StErr2;
            default: state_d = StIdle;
        endcase
    end

    // Outputs decoded from the current state.
    always_comb begin
        readyOut = 1'b1;
        resp     = RESP_OKAY;
        unique case (state_q)
            StWait: readyOut = 1'b0;
            StErr1: begin
                readyOut = 1'b0;
                resp     = RESP_ERROR;
            end
            StErr2:  resp = RESP_ERROR;
            default: ;
        endcase
    end

    // Read data is captured on the edge entering DATA. If the write ahead of us is still in
    // its data phase (memory not yet updated) and hits the same word, merge its bytes in.
    always_comb begin
        rdata_d    = rdata_q;
        rd_idx     = (state_q == StWait) ? idx_q : addr_idx;
        rd_is_read = (state_q == StWait) ? !write_q : !write;
        if ((state_d == StData) && rd_is_read) begin
            rdata_d = mem[rd_idx];
            if ((state_q == StData) && write_q && (idx_q == rd_idx)) begin
                for (int b = 0; b < BYTES; b++) begin
                    if (mask_q[b]) begin
                        rdata_d[8*b +: 8] = wData[8*b +: 8];
                    end
                end
            end
        end
    end

    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            state_q    <= StIdle;
            wait_cnt_q <= 4'd0;
            rdata_q    <= '0;
            idx_q      <= '0;
            write_q    <= 1'b0;
            mask_q     <= '0;
        end else begin
            state_q    <= state_d;
            wait_cnt_q <= wait_cnt_d;
            rdata_q    <= rdata_d;
            if (accept) begin
                idx_q   <= addr_idx;
                write_q <= write;
                mask_q  <= lane_mask;
            end
        end
    end

    // Memory is not reset; a write commits at the end of its single DATA cycle.
    always_ff @(posedge clk) begin
        if ((state_q == StData) && write_q) begin
            for (int b = 0; b < BYTES; b++) begin
                if (mask_q[b]) begin
                    mem[idx_q][8*b +: 8] <= wData[8*b +: 8];
                end
            end
        end
    end

    assign rData = rdata_q;

endmodule

// File: tb/tb_ahb_sub_mem.sv
// tb_ahb_sub_mem: two ahb_sub_mem instances (WAIT_STATES 0 and 2), each on its own bus with
// readyIn tied to readyOut. A per-transfer model predicts readyOut/resp/rData every cycle.
`timescale 1ns/1ps
module tb_ahb_sub_mem;
    import ahb_sub_mem_pkg::*;

    logic clk = 1'b0;
    logic reset;
    always #5 clk = ~clk;

    logic        sel_v   [2];
    logic [1:0]  trans_v [2];
    logic        write_v [2];
    logic [31:0] addr_v  [2];
    logic [2:0]  size_v  [2];
    logic [31:0] wdata_v [2];
    logic        inj_v   [2];
    logic [31:0] rdata_v [2];
    logic        ready_v [2];
    logic        resp_v  [2];

    ahb_sub_mem #(
        .ADDR_WIDTH(32), .DATA_WIDTH(32), .DEPTH(256), .WAIT_STATES(0)
    ) dut0 (
        .clk(clk), .reset(reset), .sel(sel_v[0]), .trans(trans_v[0]), .write(write_v[0]),
        .addr(addr_v[0]), .size(size_v[0]), .wData(wdata_v[0]), .readyIn(ready_v[0]),
        .errInject(inj_v[0]), .rData(rdata_v[0]), .readyOut(ready_v[0]), .resp(resp_v[0])
    );

    ahb_sub_mem #(
        .ADDR_WIDTH(32), .DATA_WIDTH(32), .DEPTH(256), .WAIT_STATES(2)
    ) dut2 (
        .clk(clk), .reset(reset), .sel(sel_v[1]), .trans(trans_v[1]), .write(write_v[1]),
        .addr(addr_v[1]), .size(size_v[1]), .wData(wdata_v[1]), .readyIn(ready_v[1]),
        .errInject(inj_v[1]), .rData(rdata_v[1]), .readyOut(ready_v[1]), .resp(resp_v[1])
    );

    int total = 0;
    int bad   = 0;

    // ---------------- reference model ----------------
    logic [31:0] mem_m  [2][256];
    logic [31:0] exp_rd [2];
    bit          busy   [2];
    bit          acc_p  [2];
    bit          done_p [2];
    int          cyc    [2];
    bit          c_err  [2], c_wr [2];
    int          c_idx  [2], c_off [2], c_size [2];
    bit          p_err  [2], p_wr [2];
    int          p_idx  [2], p_off [2], p_size [2];
    logic [31:0] last_addr [2];
`ifdef AHB_SUB_MEM_BURST_CHECK_EN
    logic [31:0] b_addr  [2];
    bit          b_valid [2];
`endif

    function automatic int wait_of(input int k);
        return (k == 0) ? 0 : 2;
    endfunction

    function automatic logic [31:0] init_word(input int i);
        return (32'(i) * 32'h01010101) ^ 32'hC3C3C3C3;
    endfunction

    task automatic check(input string name, input int k, input logic [31:0] act,
                         input logic [31:0] exp);
        total++;
        if (act !== exp) begin
            bad++;
            $display("FAIL %s dut%0d: got %h want %h at %0t", name, k, act, exp, $time);
        end
    endtask

    task automatic track(input int k);
        bit          exp_ready, exp_resp, last, e;
        logic [31:0] a;
        int          sz;
        if (acc_p[k]) begin
            busy[k] = 1; cyc[k] = 0;
            c_err[k] = p_err[k]; c_wr[k] = p_wr[k];
            c_idx[k] = p_idx[k]; c_off[k] = p_off[k]; c_size[k] = p_size[k];
        end else if (done_p[k]) begin
            busy[k] = 0;
        end else if (busy[k]) begin
            cyc[k]++;
        end

        if (!busy[k]) begin
            exp_ready = 1; exp_resp = 0; last = 0;
        end else if (c_err[k]) begin
            exp_ready = (cyc[k] == 1); exp_resp = 1; last = (cyc[k] == 1);
        end else begin
            exp_ready = (cyc[k] == wait_of(k)); exp_resp = 0; last = (cyc[k] == wait_of(k));
        end

        if (busy[k] && last && !c_err[k]) begin
            if (c_wr[k]) begin
                for (int b = c_off[k]; b < c_off[k] + (1 << c_size[k]); b++)
                    mem_m[k][c_idx[k]][8*b +: 8] = wdata_v[k][8*b +: 8];
            end else begin
                exp_rd[k] = mem_m[k][c_idx[k]];
            end
        end

        check("readyOut", k, 32'(ready_v[k]), 32'(exp_ready));
        check("resp", k, 32'(resp_v[k]), 32'(exp_resp));
        if (exp_ready) check("rData", k, rdata_v[k], exp_rd[k]);

        done_p[k] = busy[k] && last;
        acc_p[k]  = 0;
        if (exp_ready) begin
            if (sel_v[k] && trans_v[k][1]) begin
                a  = addr_v[k];
                sz = int'(size_v[k]);
                e  = (a >= 32'd1024) || (sz > 2) || (a % (32'd1 << sz) != 0) || inj_v[k];
`ifdef AHB_SUB_MEM_BURST_CHECK_EN
                if (trans_v[k] == TRANS_SEQ &&
                    (!b_valid[k] || a != 32'(b_addr[k] + (32'd1 << sz)))) e = 1;
                b_addr[k]  = a;
                b_valid[k] = !e;
`endif
                acc_p[k]  = 1;
                p_err[k]  = e;
                p_wr[k]   = write_v[k];
                p_idx[k]  = int'((a / 4) % 256);
                p_off[k]  = int'(a % 4);
                p_size[k] = sz;
            end else if (!sel_v[k] || trans_v[k] == TRANS_IDLE) begin
`ifdef AHB_SUB_MEM_BURST_CHECK_EN
                b_valid[k] = 0;
`endif
            end
        end
    endtask

    always @(negedge clk) begin
        for (int k = 0; k < 2; k++) begin
            if (reset) begin
                busy[k] = 0; acc_p[k] = 0; done_p[k] = 0; cyc[k] = 0; exp_rd[k] = '0;
`ifdef AHB_SUB_MEM_BURST_CHECK_EN
                b_valid[k] = 0;
`endif
                check("reset_ready", k, 32'(ready_v[k]), 32'd1);
                check("reset_resp", k, 32'(resp_v[k]), 32'd0);
                check("reset_rdata", k, rdata_v[k], 32'd0);
            end else begin
                track(k);
            end
        end
    end

    // ---------------- driver ----------------
    task automatic go_idle(input int k);
        sel_v[k] = 0; trans_v[k] = TRANS_IDLE; inj_v[k] = 0;
    endtask

    task automatic xfer(input int k, input bit wr, input logic [31:0] a, input logic [2:0] sz,
                        input logic [31:0] d, input bit inj, input logic [1:0] tr);
        int n = 0;
        bit acc = 0;
        sel_v[k] = 1; trans_v[k] = tr; write_v[k] = wr; addr_v[k] = a;
        size_v[k] = sz; inj_v[k] = inj;
        while (!acc && n < 100) begin
            @(negedge clk); acc = ready_v[k];
            @(posedge clk); #1; n++;
        end
        total++;
        if (!acc) begin
            bad++;
            $display("FAIL accept_timeout dut%0d: readyOut low for %0d cycles, want high", k, n);
        end
        wdata_v[k] = wr ? d : $urandom();
        go_idle(k);
        last_addr[k] = a;
    endtask

    task automatic settle(input int k);
        int n = 0;
        bit rdy = 0;
        go_idle(k);
        while (!rdy && n < 100) begin
            @(negedge clk); rdy = ready_v[k];
            @(posedge clk); #1; n++;
        end
        total++;
        if (!rdy) begin
            bad++;
            $display("FAIL settle_timeout dut%0d: readyOut low for %0d cycles, want high", k, n);
        end
    endtask

    task automatic xfer_err(input int k, input bit wr, input logic [31:0] a,
                            input logic [2:0] sz, input logic [31:0] d, input bit inj);
        xfer(k, wr, a, sz, d, inj, TRANS_NONSEQ);
        @(negedge clk);
        check("err1_ready", k, 32'(ready_v[k]), 32'd0);
        check("err1_resp", k, 32'(resp_v[k]), 32'd1);
        @(negedge clk);
        check("err2_ready", k, 32'(ready_v[k]), 32'd1);
        check("err2_resp", k, 32'(resp_v[k]), 32'd1);
        @(posedge clk); #1;
    endtask

    task automatic run_seq(input int k);
        int          lows, n, r, sz, wd;
        bit          wr, inj;
        logic [31:0] a;
        logic [1:0]  tr;

        for (int i = 0; i < 256; i++)
            xfer(k, 1, 32'(i * 4), 3'd2, init_word(i), 0, TRANS_NONSEQ);

        // Back-to-back write then read of the same word.
        xfer(k, 1, 32'h10, 3'd2, 32'hDEADBEEF, 0, TRANS_NONSEQ);
        xfer(k, 0, 32'h10, 3'd2, 32'h0, 0, TRANS_NONSEQ);
        settle(k);
        check("fwd_rdata", k, rdata_v[k], 32'hDEADBEEF);
        check("model_fwd", k, exp_rd[k], 32'hDEADBEEF);

        // Wait-state count on a single read.
        xfer(k, 0, 32'h04, 3'd2, 32'h0, 0, TRANS_NONSEQ);
        lows = 0; n = 0;
        forever begin
            @(negedge clk);
            if (ready_v[k] || n >= 20) break;
            lows++; n++;
        end
        check("wait_cycles", k, 32'(lows), 32'(wait_of(k)));
        check("wait_resp", k, 32'(resp_v[k]), 32'd0);
        check("wait_rdata", k, rdata_v[k], 32'hC2C2C2C2);
        @(posedge clk); #1;

        // Byte write into a known word.
        xfer(k, 1, 32'h20, 3'd2, 32'h11223344, 0, TRANS_NONSEQ);
        xfer(k, 1, 32'h21, 3'd0, 32'hAAAAAAAA, 0, TRANS_NONSEQ);
        xfer(k, 0, 32'h20, 3'd2, 32'h0, 0, TRANS_NONSEQ);
        settle(k);
        check("byte_rdata", k, rdata_v[k], 32'h1122AA44);

        // Out-of-range write must not alias onto word 0.
        xfer_err(k, 1, 32'h400, 3'd2, 32'h55555555, 0);
        xfer(k, 0, 32'h00, 3'd2, 32'h0, 0, TRANS_NONSEQ);
        settle(k);
        check("oor_rdata", k, rdata_v[k], 32'hC3C3C3C3);

        // Injected error on a write, then a read of the old value.
        xfer_err(k, 1, 32'h08, 3'd2, 32'h12345678, 1);
        xfer(k, 0, 32'h08, 3'd2, 32'h0, 0, TRANS_NONSEQ);
        settle(k);
        check("inj_rdata", k, rdata_v[k], 32'hC1C1C1C1);

        // NONSEQ 0x0, SEQ 0x4, SEQ 0xC.
        xfer(k, 0, 32'h00, 3'd2, 32'h0, 0, TRANS_NONSEQ);
        xfer(k, 0, 32'h04, 3'd2, 32'h0, 0, TRANS_SEQ);
        xfer(k, 0, 32'h0C, 3'd2, 32'h0, 0, TRANS_SEQ);
        settle(k);
`ifdef AHB_SUB_MEM_BURST_CHECK_EN
        check("burst_rdata", k, rdata_v[k], 32'hC2C2C2C2);
`else
        check("burst_rdata", k, rdata_v[k], 32'hC0C0C0C0);
`endif

        // Randomised traffic over a small window so forwarding hits often.
        for (int t = 0; t < 200; t++) begin
            r = $urandom_range(0, 99);
            if (r < 12) begin
                case ($urandom_range(0, 2))
                    0: begin sel_v[k] = 0; trans_v[k] = TRANS_IDLE; end
                    1: begin sel_v[k] = 1; trans_v[k] = TRANS_BUSY; end
                    default: begin sel_v[k] = 0; trans_v[k] = TRANS_NONSEQ; end
                endcase
                @(posedge clk); #1;
                go_idle(k);
                continue;
            end
            wr  = 1'($urandom_range(0, 1));
            inj = ($urandom_range(0, 99) < 5);
            sz  = ($urandom_range(0, 99) < 92) ? $urandom_range(0, 2) : $urandom_range(3, 7);
            wd  = $urandom_range(0, 15);
            a   = 32'(wd * 4) + 32'(($urandom_range(0, 3) >> sz) << sz);
            r   = $urandom_range(0, 99);
            if (r < 5) a = 32'(wd * 4) + 32'd1;
            else if (r < 10) a = 32'h400 + 32'($urandom_range(0, 255) * 4);
            tr = TRANS_NONSEQ;
            if ($urandom_range(0, 99) < 35 && sz <= 2 &&
                32'(last_addr[k] + (32'd1 << sz)) < 32'd1024) begin
                tr = TRANS_SEQ;
                a  = 32'(last_addr[k] + (32'd1 << sz));
            end
            xfer(k, wr, a, 3'(sz), $urandom(), inj, tr);
        end
        settle(k);
    endtask

    initial begin
        reset = 1'b1;
        for (int k = 0; k < 2; k++) begin
            go_idle(k);
            write_v[k] = 0; addr_v[k] = '0; size_v[k] = 3'd2; wdata_v[k] = '0;
            last_addr[k] = '0;
        end
        repeat (3) @(posedge clk);
        #1;
        for (int k = 0; k < 2; k++) begin
            check("rst_lit_ready", k, 32'(ready_v[k]), 32'd1);
            check("rst_lit_resp", k, 32'(resp_v[k]), 32'd0);
            check("rst_lit_rdata", k, rdata_v[k], 32'd0);
        end
        reset = 1'b0;
        fork
            run_seq(0);
            run_seq(1);
        join
        repeat (3) @(posedge clk);
        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end

    initial begin
        #500000;
        $display("FAIL watchdog: simulation still running at %0t, want finished", $time);
        bad++;
        $display("test done: total=%0d bad=%0d", total, bad);
        $fatal(1, "watchdog expired");
    end

endmodule
